pulse2wb: RTL
=============

// Module: pulse2wb
// PURPOSE
//  Pulse-interval capture peripheral: the receive-side counterpart of the Wishbone pulse generator.
//  - Samples an external, asynchronous pulse line and measures the clock-cycle interval between consecutive rising edges.
//  - Exposes the last captured period plus a status/control register to the CPU over the same single-cycle Wishbone slave handshake.
//  - Sits on the SoC peripheral bus beside the pulse generator; generator loopback is the primary use.
// PARAMETERS
//  DSIZE        8  data/counter width; must be >= 3
//  SYNC_STAGES  2  synchronizer flops on i_pulse; must be >= 2
// PORTS
//  i_clk    in   1      single system clock
//  i_rst_n  in   1      asynchronous, active-low reset
//  i_stb    in   1      Wishbone strobe
//  i_we     in   1      1 = write, 0 = read
//  i_adr    in   1      0 = PERIOD (read-only), 1 = CTRL/STATUS
//  i_dat    in   DSIZE  write data
//  i_e      in   1      measurement enable
//  i_pulse  in   1      asynchronous pulse input
//  o_ack    out  1      Wishbone acknowledge
//  o_dat    out  DSIZE  read data; 0 whenever o_ack=0
//  o_irq    out  1      level interrupt = valid & ien
// BEHAVIOUR
//  Reset: o_ack=0, o_dat=0, o_irq=0, PERIOD=0, cnt=0, valid=ovf=ien=0, meas FSM=DISARM, bus FSM=IDLE.
//  Bus FSM (IDLE/ACCESS):
//   - IDLE: i_stb -> ACCESS. ACCESS -> IDLE unconditionally. o_ack = (state==ACCESS); one-cycle pulse, one cycle after i_stb.
//   - Read data is registered on the IDLE->ACCESS transition, so o_dat is valid in the o_ack cycle.
//   - Register effects (write decode, read-clear) commit at the end of the ACCESS cycle.
//   - Read adr0 returns PERIOD and clears valid.
//   - Read adr1 returns {0.., armed, ovf, valid} in bits [2:0].
//   - Write adr1: bit0=1 -> re-arm (FSM->DISARM, cnt=0, valid=0, ovf=0); bit1 -> ien. Write adr0: acked, ignored.
//  Input path: SYNC_STAGES-flop synchronizer, then rising-edge detect (sync_q & ~sync_q_d).
//   - edge is a 1-cycle strobe, SYNC_STAGES+1 cycles after the i_pulse rise.
//   - Pulses shorter than 1 clock may be missed.
//  Measurement FSM:
//   - DISARM: cnt held 0. edge & i_e -> MEASURE with cnt=1; no capture.
//   - MEASURE, no edge: cnt=cnt+1, saturating at all-ones; the saturate transition sets sticky ovf.
//   - MEASURE, edge: PERIOD<=cnt, valid<=1, cnt<=1. Back-to-back edge strobes (2 cycles apart) capture 2.
//   - MEASURE, i_e low: -> DISARM, cnt=0. PERIOD, valid and ovf are retained.
//   - armed = (state==MEASURE).
//  Simultaneous events:
//   - Capture and PERIOD read in the same ACCESS cycle: read returns the old PERIOD; valid stays 1 (capture wins).
//   - Re-arm write and edge in the same cycle: re-arm wins; the edge is discarded.
//   - i_e low and edge in the same cycle: no capture.
//  Async reset mid-operation returns every state element to its reset value immediately; the next bus cycle starts from IDLE.
//  Width rules: cnt and PERIOD are DSIZE unsigned; no wrap-around (saturation only).
// STRUCTURE
//  Shared package/header holds:
//   - bus state codes WB_IDLE/WB_ACCESS and meas state codes MS_DISARM/MS_MEASURE
//   - register offsets REG_PERIOD=0, REG_CTRL=1
//   - status bits ST_VALID=0, ST_OVF=1, ST_ARMED=2; ctrl bits CT_REARM=0, CT_IEN=1
//  Sub-module pulse_sync_edge (SYNC_STAGES param; i_clk, i_rst_n, i_async -> o_edge): synchronizer plus edge detect, reusable by other async inputs.
//  Top level holds the bus FSM, the meas FSM, counter and registers.
// TESTING
//  1. Reset, read adr0 and adr1 -> o_ack 1 cycle after i_stb, o_dat=0, o_irq=0.
//  2. i_e=1; rising edges 10 clocks apart x3 -> PERIOD=10, valid=1; read adr0 -> 10, then status bit0=0.
//  3. Edges 300 clocks apart, DSIZE=8 -> PERIOD=255, status=3'b111 (armed, ovf, valid); write adr1=8'h01 -> status=0.
//  4. Write adr1=8'h02, capture edge -> o_irq=1; read adr0 -> o_irq falls after the ack cycle.
//  5. Edge arriving in the same cycle as a PERIOD read ACCESS -> o_dat=old value, valid remains 1, new PERIOD readable next.
//  6. Drop i_e mid-interval, then edges -> no capture; raise i_e -> first edge re-arms, second edge captures correct interval.

Source files
------------

// File: rtl/pulse2wb_pkg.sv
// Shared encodings for the pulse-interval capture peripheral:
// FSM state codes, register offsets and status/control bit positions.
package pulse2wb_pkg;

  typedef enum logic {
    WB_IDLE   = 1'b0,
    WB_ACCESS = 1'b1
  } wb_state_e;

  typedef enum logic {
    MS_DISARM  = 1'b0,
    MS_MEASURE = 1'b1
  } ms_state_e;

  localparam logic REG_PERIOD = 1'b0;
  localparam logic REG_CTRL   = 1'b1;

  localparam int unsigned ST_VALID = 0;
  localparam int unsigned ST_OVF   = 1;
  localparam int unsigned ST_ARMED = 2;

  localparam int unsigned CT_REARM = 0;
  localparam int unsigned CT_IEN   = 1;

endpackage

// File: rtl/pulse_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input followed by a
// registered rising-edge detector (1-cycle strobe, SYNC_STAGES+1 cycles late).
module pulse_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_edge
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_q_d;
  logic                   edge_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q   <= '0;
      sync_q_d <= 1'b0;
      edge_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], i_async};
      sync_q_d <= sync_q[SYNC_STAGES-1];
      edge_q   <= sync_q[SYNC_STAGES-1] & ~sync_q_d;
    end
  end

  assign o_edge = edge_q;

endmodule

// File: rtl/pulse2wb.sv
// Pulse-interval capture peripheral: measures cycles between rising edges of
// an async pulse line and exposes PERIOD and CTRL/STATUS over a Wishbone slave.
module pulse2wb
  import pulse2wb_pkg::*;
#(
  parameter int unsigned DSIZE       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_stb,
  input  logic             i_we,
  input  logic             i_adr,
  input  logic [DSIZE-1:0] i_dat,
  input  logic             i_e,
  input  logic             i_pulse,
  output logic             o_ack,
  output logic [DSIZE-1:0] o_dat,
  output logic             o_irq
);

  localparam logic [DSIZE-1:0] CNT_MAX = '1;

  wb_state_e        wb_q, wb_d;
  ms_state_e        ms_q, ms_d;
  logic [DSIZE-1:0] cnt_q, cnt_d;
  logic [DSIZE-1:0] period_q, period_d;
  logic [DSIZE-1:0] rdata_q, rdata_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             ien_q, ien_d;
  logic             we_q, we_d;
  logic             adr_q, adr_d;
  logic [1:0]       wctl_q, wctl_d;

  logic             pulse_edge;
  logic             access, wr_ctrl, rearm, rd_period, capture;
  logic [DSIZE-1:0] status;
  logic             unused_dat;

  assign unused_dat = ^i_dat[DSIZE-1:2];

  pulse_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_pulse),
    .o_edge  (pulse_edge)
  );

  assign access    = (wb_q == WB_ACCESS);
  assign wr_ctrl   = access & we_q & (adr_q == REG_CTRL);
  assign rearm     = wr_ctrl & wctl_q[CT_REARM];
  assign rd_period = access & ~we_q & (adr_q == REG_PERIOD);

  always_comb begin
    status           = '0;
    status[ST_VALID] = valid_q;
    status[ST_OVF]   = ovf_q;
    status[ST_ARMED] = (ms_q == MS_MEASURE);
  end

  always_comb begin
    wb_d     = wb_q;
    ms_d     = ms_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    rdata_d  = rdata_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    ien_d    = ien_q;
    we_d     = we_q;
    adr_d    = adr_q;
    wctl_d   = wctl_q;
    capture  = 1'b0;

    case (wb_q)
      WB_IDLE: begin
        if (i_stb) begin
          wb_d    = WB_ACCESS;
          we_d    = i_we;
          adr_d   = i_adr;
          wctl_d  = i_dat[1:0];
          rdata_d = (i_adr == REG_CTRL) ? status : period_q;
        end
      end
      WB_ACCESS: wb_d = WB_IDLE;
      default:   wb_d = WB_IDLE;
    endcase

    case (ms_q)
      MS_DISARM: begin
        cnt_d = '0;
        if (pulse_edge && i_e) begin
          ms_d  = MS_MEASURE;
          cnt_d = DSIZE'(1);
        end
      end
      MS_MEASURE: begin
        if (!i_e) begin
          ms_d  = MS_DISARM;
          cnt_d = '0;
        end else if (pulse_edge) begin
          period_d = cnt_q;
          capture  = 1'b1;
          cnt_d    = DSIZE'(1);
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + DSIZE'(1);
          if (cnt_q == CNT_MAX - DSIZE'(1)) ovf_d = 1'b1;
        end
      end
      default: ms_d = MS_DISARM;
    endcase

    // Priority: re-arm over capture over read-clear of valid.
    if (rd_period) valid_d = 1'b0;
    if (capture)   valid_d = 1'b1;
    if (wr_ctrl)   ien_d   = wctl_q[CT_IEN];
    if (rearm) begin
      ms_d     = MS_DISARM;
      cnt_d    = '0;
      period_d = period_q;
      valid_d  = 1'b0;
      ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wb_q     <= WB_IDLE;
      ms_q     <= MS_DISARM;
      cnt_q    <= '0;
      period_q <= '0;
      rdata_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      ien_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= 1'b0;
      wctl_q   <= '0;
    end else begin
      wb_q     <= wb_d;
      ms_q     <= ms_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      rdata_q  <= rdata_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      ien_q    <= ien_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      wctl_q   <= wctl_d;
    end
  end

  assign o_ack = access;
  assign o_dat = access ? rdata_q : '0;
  assign o_irq = valid_q & ien_q;

endmodule
